// File: rtl/window_gen.sv
// window_gen: 7x7 sliding-window generator over a raster pixel stream using six line buffers
//
// Ports:
//   i_clk           clock, all state changes on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_data_enable   qualifies i_data_in, one pixel accepted per cycle when high
//   i_data_in       8-bit raster-order pixel
//   i_frame_sync    forces the accepted pixel to row 0, col 0
//   o_win_valid     a complete 7x7 window is present on o_row0..o_row6
//   o_row0..o_row6  window rows, row0 oldest line, bits [7:0] newest pixel
//   o_center_pixel  window centre, o_row3[31:24]
//   o_win_x/o_win_y image coordinates of the window centre
module window_gen #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_data_enable,
   input  logic [7:0]  i_data_in,
   input  logic        i_frame_sync,
   output logic        o_win_valid,
   output logic [55:0] o_row0,
   output logic [55:0] o_row1,
   output logic [55:0] o_row2,
   output logic [55:0] o_row3,
   output logic [55:0] o_row4,
   output logic [55:0] o_row5,
   output logic [55:0] o_row6,
   output logic [7:0]  o_center_pixel,
   output logic [7:0]  o_win_x,
   output logic [7:0]  o_win_y
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
   logic [CW-1:0] r_col, w_col, w_col_nxt;
   logic [RW-1:0] r_row, w_row, w_row_nxt;
   logic [7:0]    r_lb [6][IMG_WIDTH];
   logic [55:0]   r_win [7];
   logic [7:0]    w_new [7];
   logic          w_hit;
   // frame_sync relabels the current pixel as the frame origin before it is used
   always_comb begin
      w_col     = i_frame_sync ? '0 : r_col;
      w_row     = i_frame_sync ? '0 : r_row;
      w_col_nxt = (w_col == LAST_COL) ? '0 : w_col + 1'b1;
      w_row_nxt = (w_col != LAST_COL) ? w_row : (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
      w_hit     = i_data_enable && (w_col >= CW'(6)) && (w_row >= RW'(6));
      // r_lb[0] holds the previous line, r_lb[5] the line six lines back
      for (int r = 0; r < 6; r++) w_new[r] = r_lb[5-r][w_col];
      w_new[6] = i_data_in;
   end
   // line buffers carry no reset; stale lines are masked by the row>=6 rule
   always_ff @(posedge i_clk) begin
      if (i_data_enable) begin
         r_lb[0][w_col] <= i_data_in;
         for (int k = 5; k > 0; k--) r_lb[k][w_col] <= r_lb[k-1][w_col];
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col       <= '0;
         r_row       <= '0;
         o_win_valid <= 1'b0;
         o_win_x     <= '0;
         o_win_y     <= '0;
         for (int r = 0; r < 7; r++) r_win[r] <= '0;
      end else begin
         o_win_valid <= w_hit;
         if (i_data_enable) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            for (int r = 0; r < 7; r++) r_win[r] <= {r_win[r][47:0], w_new[r]};
         end
         if (w_hit) begin
            o_win_x <= 8'(w_col) - 8'd3;
            o_win_y <= 8'(w_row) - 8'd3;
         end
      end
   end
   assign o_row0         = r_win[0];
   assign o_row1         = r_win[1];
   assign o_row2         = r_win[2];
   assign o_row3         = r_win[3];
   assign o_row4         = r_win[4];
   assign o_row5         = r_win[5];
   assign o_row6         = r_win[6];
   assign o_center_pixel = r_win[3][31:24];
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: table-driven and model-checked bench for window_gen at 8x8
module tb_window_gen;
   localparam int W = 8;
   localparam int H = 8;
   logic clk = 1'b0, rst_n = 1'b0, de = 1'b0, fs = 1'b0;
   logic [7:0] din = '0;
   logic vld;
   logic [55:0] r0, r1, r2, r3, r4, r5, r6;
   logic [7:0] cp, wx, wy;
   logic [55:0] act [7];
   always #5 clk = ~clk;
   window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data_enable(de), .i_data_in(din), .i_frame_sync(fs),
      .o_win_valid(vld), .o_row0(r0), .o_row1(r1), .o_row2(r2), .o_row3(r3), .o_row4(r4),
      .o_row5(r5), .o_row6(r6), .o_center_pixel(cp), .o_win_x(wx), .o_win_y(wy)
   );
   always_comb begin
      act[0] = r0;
      act[1] = r1;
      act[2] = r2;
      act[3] = r3;
      act[4] = r4;
      act[5] = r5;
      act[6] = r6;
   end
   typedef struct {
      logic [7:0]  d;
      logic        fs;
      logic        ev;
      logic [7:0]  ex, ey, ec;
      logic [55:0] er0, er6;
   } vec_t;
   vec_t tbl [W*H];
   int n_vec = 0, n_err = 0, pulses = 0, pos = 0;
   logic [7:0] hist [W][$];
   task automatic chk(string nm, logic [55:0] a, logic [55:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask
   // Reference: a pixel's place is its count since sync modulo the frame;
   // each column remembers the last seven pixels written there.
   task automatic step(logic d_e, logic [7:0] d, logic f);
      logic ev;
      int c, r, x;
      logic [55:0] er [7];
      logic [7:0] ex, ey;
      de = d_e;
      din = d;
      fs = f;
      ev = 1'b0;
      ex = '0;
      ey = '0;
      if (d_e) begin
         if (f) pos = 0;
         c = pos % W;
         r = pos / W;
         hist[c].push_back(d);
         if (hist[c].size() > 7) void'(hist[c].pop_front());
         ev = (c >= 6) && (r >= 6);
         if (ev)
            for (int rr = 0; rr < 7; rr++)
               for (int j = 0; j < 7; j++) begin
                  x = c - 6 + j;
                  er[rr][(6-j)*8 +: 8] = hist[x][hist[x].size() - 7 + rr];
               end
         ex = 8'(c - 3);
         ey = 8'(r - 3);
         pos = (pos + 1) % (W * H);
      end
      @(posedge clk);
      #1;
      chk("model_valid", 56'(vld), 56'(ev));
      if (vld) pulses++;
      if (ev) begin
         chk("model_x", 56'(wx), 56'(ex));
         chk("model_y", 56'(wy), 56'(ey));
         chk("model_center", 56'(cp), 56'(er[3][31:24]));
         for (int rr = 0; rr < 7; rr++) chk($sformatf("model_row%0d", rr), act[rr], er[rr]);
      end
   endtask
   task automatic run_table(logic use_fs);
      int p0, first;
      p0 = pulses;
      first = -1;
      for (int i = 0; i < W*H; i++) begin
         step(1'b1, tbl[i].d, use_fs & tbl[i].fs);
         chk("tbl_valid", 56'(vld), 56'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk("tbl_x", 56'(wx), 56'(tbl[i].ex));
            chk("tbl_y", 56'(wy), 56'(tbl[i].ey));
            chk("tbl_center", 56'(cp), 56'(tbl[i].ec));
            chk("tbl_row0", r0, tbl[i].er0);
            chk("tbl_row6", r6, tbl[i].er6);
         end
         if (vld && first < 0) first = i;
      end
      chk("tbl_pulses", 56'(pulses - p0), 56'(4));
      chk("tbl_first", 56'(first), 56'(54));
   endtask
   initial begin
      int x, y, idx, guard, p0, first;
      for (int i = 0; i < W*H; i++) begin
         x = i % W;
         y = i / W;
         tbl[i].d   = 8'(i);
         tbl[i].fs  = (i == 0);
         tbl[i].ev  = (x >= 6) && (y >= 6);
         tbl[i].ex  = 8'(x - 3);
         tbl[i].ey  = 8'(y - 3);
         tbl[i].ec  = 8'((y - 3) * W + x - 3);
         tbl[i].er0 = '0;
         tbl[i].er6 = '0;
         for (int j = 0; j < 7; j++) begin
            tbl[i].er0[(6-j)*8 +: 8] = 8'((y - 6) * W + x - 6 + j);
            tbl[i].er6[(6-j)*8 +: 8] = 8'(y * W + x - 6 + j);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 56'(vld), 56'(0));
      chk("rst_x", 56'(wx), 56'(0));
      chk("rst_y", 56'(wy), 56'(0));
      chk("rst_center", 56'(cp), 56'(0));
      chk("rst_row0", r0, 56'(0));
      chk("rst_row6", r6, 56'(0));
      rst_n = 1'b1;
      run_table(1'b1);
      run_table(1'b0);
      // idle cycles interleaved; frame_sync while idle must be ignored
      p0 = pulses;
      idx = 0;
      guard = 0;
      while (idx < W*H && guard < 2000) begin
         guard++;
         if ($urandom_range(0, 1) == 1) begin
            step(1'b1, 8'(idx), idx == 0);
            idx++;
         end else step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      end
      chk("idle_done", 56'(idx), 56'(W*H));
      chk("idle_pulses", 56'(pulses - p0), 56'(4));
      // frame_sync mid-frame restarts the counters
      for (int i = 0; i < 20; i++) step(1'b1, 8'(i), i == 0);
      first = -1;
      for (int k = 0; k < 60; k++) begin
         step(1'b1, 8'(20 + k), k == 0);
         if (vld && first < 0) begin
            first = k;
            chk("sync20_x", 56'(wx), 56'(3));
            chk("sync20_y", 56'(wy), 56'(3));
         end
      end
      chk("sync20_first", 56'(first), 56'(54));
      // asynchronous reset in the middle of a frame
      for (int i = 0; i < 40; i++) step(1'b1, 8'(i), i == 0);
      #2;
      rst_n = 1'b0;
      de = 1'b0;
      #1;
      chk("arst_valid", 56'(vld), 56'(0));
      chk("arst_row0", r0, 56'(0));
      chk("arst_row6", r6, 56'(0));
      chk("arst_center", 56'(cp), 56'(0));
      chk("arst_x", 56'(wx), 56'(0));
      chk("arst_y", 56'(wy), 56'(0));
      pos = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_table(1'b0);
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
